// File: rtl/mbist_mem_if.sv
// Memory-side bus between the March C- controller and the single-port memory
// under test.
//   write_read : 1 = write, 0 = read (controller -> memory)
//   address    : word address (controller -> memory)
//   wdata      : write data, one cycle ahead of its write command (controller -> memory)
//   rdata      : read data, two cycles after its read command (memory -> controller)
interface mbist_mem_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output write_read, output address, output wdata, input rdata);
  modport slave  (input write_read, input address, input wdata, output rdata);
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller.
// Streams the 10N-operation March C- sequence to a single-port memory one
// operation per cycle, checks every read against its expected pattern and
// reports pass/fail plus first-failure diagnostics.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin a test (honoured only when idle or done)
//   mem          : memory bus (master side), see mbist_mem_if
//   busy         : test in progress (RUN or DRAIN)
//   done         : test finished; held until the next accepted start
//   fail         : sticky, at least one read mismatched
//   fail_addr    : address of the first mismatch
//   fail_elem    : March element index of the first mismatch
//   fail_syn     : rdata XOR expected at the first mismatch
//   fail_count   : number of mismatching reads, saturating at 255
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  mbist_mem_if.master           mem,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_syn,
  output logic [7:0]            fail_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] D0 = '0;
  localparam logic [DATA_WIDTH-1:0] D1 = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [1:0]            drain_cnt;

  // Operation generator: element, address and read/write phase of the
  // operation that will be issued next.
  logic [2:0]            elem;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  phase;
  logic                  gen_done;

  // Issue stage S0 (drives wdata) and S1 (drives command/address).
  logic                  s0_valid, s0_wr;
  logic [ADDR_WIDTH-1:0] s0_addr;
  logic [DATA_WIDTH-1:0] s0_exp;
  logic [2:0]            s0_elem;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  s1_rd;
  logic [DATA_WIDTH-1:0] s1_exp;
  logic [2:0]            s1_elem;

  // Check pipeline: two stages so a read's expectation meets its rdata.
  logic                  c1_rd, c2_rd;
  logic [DATA_WIDTH-1:0] c1_exp, c2_exp;
  logic [2:0]            c1_elem, c2_elem;
  logic [ADDR_WIDTH-1:0] c1_addr, c2_addr;

  // Decode of the pending operation.
  logic                  accept, issue;
  logic                  two_op, op_wr, elem_down, elem_end, op_last;
  logic [DATA_WIDTH-1:0] op_data;
  logic [DATA_WIDTH-1:0] syn;
  logic                  mismatch;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    accept    = start && (state == S_IDLE || state == S_DONE);
    issue     = accept || (state == S_RUN && !gen_done);
    two_op    = (elem != 3'd0) && (elem != 3'd5);
    op_wr     = (elem == 3'd0) || phase;
    elem_down = (elem == 3'd3) || (elem == 3'd4);
    elem_end  = (elem_down ? (addr == '0) : (addr == LAST_ADDR)) && (!two_op || phase);
    op_last   = (elem == 3'd5) && (addr == LAST_ADDR);
    op_data   = D0;
    if (op_wr) begin
      if (elem == 3'd1 || elem == 3'd3) op_data = D1;
    end else begin
      if (elem == 3'd2 || elem == 3'd4) op_data = D1;
    end
    syn       = mem.rdata ^ c2_exp;
    mismatch  = c2_rd && (syn != '0);
  end

  // FSM and operation generator.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      elem      <= '0;
      addr      <= '0;
      phase     <= 1'b0;
      gen_done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            gen_done <= 1'b0;
          end
        end
        S_RUN: begin
          // Generator emptied last cycle; the final op now sits in S0.
          if (gen_done) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == 2'd2) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (issue) begin
        if (op_last) begin
          // Park the generator on operation 0 for the next run.
          elem     <= '0;
          addr     <= '0;
          phase    <= 1'b0;
          gen_done <= 1'b1;
        end else if (two_op && !phase) begin
          phase <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (elem_end) begin
            elem <= elem + 3'd1;
            // Elements 3 and 4 walk downwards from the top address.
            addr <= (elem == 3'd2 || elem == 3'd3) ? LAST_ADDR : '0;
          end else begin
            addr <= elem_down ? addr - ADDR_ONE : addr + ADDR_ONE;
          end
        end
      end
    end
  end

  // Issue and check pipelines, plus result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid   <= 1'b0;
      s0_wr      <= 1'b0;
      s0_addr    <= '0;
      s0_exp     <= '0;
      s0_elem    <= '0;
      wdata_q    <= '0;
      cmd_wr     <= 1'b0;
      cmd_addr   <= '0;
      s1_rd      <= 1'b0;
      s1_exp     <= '0;
      s1_elem    <= '0;
      c1_rd      <= 1'b0;
      c1_exp     <= '0;
      c1_elem    <= '0;
      c1_addr    <= '0;
      c2_rd      <= 1'b0;
      c2_exp     <= '0;
      c2_elem    <= '0;
      c2_addr    <= '0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_syn   <= '0;
      fail_count <= '0;
    end else begin
      s0_valid <= issue;
      s0_wr    <= issue && op_wr;
      s0_addr  <= issue ? addr : '0;
      s0_exp   <= issue ? op_data : '0;
      s0_elem  <= issue ? elem : '0;
      wdata_q  <= (issue && op_wr) ? op_data : '0;

      cmd_wr   <= s0_valid && s0_wr;
      cmd_addr <= s0_addr;
      s1_rd    <= s0_valid && !s0_wr;
      s1_exp   <= s0_exp;
      s1_elem  <= s0_elem;

      c1_rd    <= s1_rd;
      c1_exp   <= s1_exp;
      c1_elem  <= s1_elem;
      c1_addr  <= cmd_addr;
      c2_rd    <= c1_rd;
      c2_exp   <= c1_exp;
      c2_elem  <= c1_elem;
      c2_addr  <= c1_addr;

      if (accept) begin
        fail       <= 1'b0;
        fail_addr  <= '0;
        fail_elem  <= '0;
        fail_syn   <= '0;
        fail_count <= '0;
      end else if (mismatch) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= c2_addr;
          fail_elem <= c2_elem;
          fail_syn  <= syn;
        end
        if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
      end
    end
  end

  assign mem.write_read = cmd_wr;
  assign mem.address    = cmd_addr;
  assign mem.wdata      = wdata_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed testbench for mbist_march_ctrl with a behavioural fault_mem model
// (write data one cycle ahead of the command, two-cycle read latency,
// optional stuck-at or neighbourhood coupling fault).
module tb_mbist_march_ctrl;

  localparam int NOPS   = 160;
  localparam int NLOG   = 200;
  localparam int CF_ADDR = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, fail;
  logic [3:0] fail_addr;
  logic [2:0] fail_elem;
  logic [7:0] fail_syn, fail_count;

  int n_checks = 0;
  int n_fail   = 0;
  int fault_mode;  // 0 none, 1 addr 5 bit 3 stuck-at-1, 2 coupling at CF_ADDR

  mbist_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) mem_bus ();

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem        (mem_bus),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem),
    .fail_syn   (fail_syn),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  // ---------------- fault_mem model ----------------
  logic [7:0] mem [0:15];
  logic [7:0] wd_d, rd1, rd2;
  logic [3:0] mem_pat;

  // Coupling neighbourhood: near-low, near-high, far-high, far-low bit 5.
  assign mem_pat = {mem[CF_ADDR-1][5], mem[CF_ADDR+1][5], mem[CF_ADDR+2][5], mem[CF_ADDR-2][5]};
  assign mem_bus.rdata = rd2;

  function automatic logic [7:0] mem_store(input int a, input logic [7:0] old_v,
                                           input logic [7:0] new_v, input logic [3:0] pat);
    logic [7:0] v;
    v = new_v;
    if (fault_mode == 1 && a == 5) v = new_v | 8'h08;
    if (fault_mode == 2 && a == CF_ADDR && pat == 4'b1001) v[5] = old_v[5];
    return v;
  endfunction

  always @(posedge clk) begin
    wd_d <= mem_bus.wdata;
    rd1  <= mem[mem_bus.address];
    rd2  <= rd1;
    if (mem_bus.write_read)
      mem[mem_bus.address] <= mem_store(int'(mem_bus.address), mem[mem_bus.address], wd_d, mem_pat);
  end

  // ---------------- March C- reference ----------------
  function automatic void op_of(input int k, output logic wr, output logic [3:0] a,
                                output logic [7:0] d, output logic [2:0] e);
    int j, i;
    if (k < 16) begin
      wr = 1'b1; a = 4'(k); d = 8'h00; e = 3'd0;
    end else if (k < 144) begin
      j  = k - 16;
      e  = 3'(1 + j / 32);
      i  = (j % 32) / 2;
      wr = (j % 2) == 1;
      a  = (e >= 3'd3) ? 4'(15 - i) : 4'(i);
      if (wr) d = (e == 3'd1 || e == 3'd3) ? 8'hFF : 8'h00;
      else    d = (e == 3'd2 || e == 3'd4) ? 8'hFF : 8'h00;
    end else begin
      wr = 1'b0; a = 4'(k - 144); d = 8'h00; e = 3'd5;
    end
  endfunction

  // Runs the whole March on a private copy of the faulty memory.
  task automatic ref_march(output int cnt, output logic [3:0] fa, output logic [2:0] fe,
                           output logic [7:0] fs);
    logic [7:0] rm [16];
    logic       wr;
    logic [3:0] a;
    logic [7:0] d;
    logic [2:0] e;
    for (int i = 0; i < 16; i++) rm[i] = 8'h00;
    cnt = 0; fa = '0; fe = '0; fs = '0;
    for (int k = 0; k < NOPS; k++) begin
      op_of(k, wr, a, d, e);
      if (wr)
        rm[a] = mem_store(int'(a), rm[a], d,
                          {rm[CF_ADDR-1][5], rm[CF_ADDR+1][5], rm[CF_ADDR+2][5], rm[CF_ADDR-2][5]});
      else if (rm[a] != d) begin
        if (cnt == 0) begin fa = a; fe = e; fs = rm[a] ^ d; end
        if (cnt < 255) cnt++;
      end
    end
  endtask

  // ---------------- run logging ----------------
  logic       lg_wr    [NLOG];
  logic [3:0] lg_addr  [NLOG];
  logic [7:0] lg_wdata [NLOG];
  logic       lg_busy  [NLOG];
  logic       lg_done  [NLOG];
  logic       lg_fail  [NLOG];
  logic [7:0] lg_cnt   [NLOG];

  // Cycle 0 is the cycle whose closing edge samples start.
  task automatic do_run(input bit extra_starts);
    for (int r = 0; r < NLOG; r++) begin
      @(negedge clk);
      lg_wr[r]    = mem_bus.write_read;
      lg_addr[r]  = mem_bus.address;
      lg_wdata[r] = mem_bus.wdata;
      lg_busy[r]  = busy;
      lg_done[r]  = done;
      lg_fail[r]  = fail;
      lg_cnt[r]   = fail_count;
      start = (r == 0) || (extra_starts && (r == 20 || r == 100));
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    #2;
    n_checks++;
    if ({mem_bus.write_read, mem_bus.address, mem_bus.wdata, busy, done, fail,
         fail_addr, fail_elem, fail_syn, fail_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b fail=%b wr=%b addr=%h wdata=%h cnt=%0d, expected all zero",
               busy, done, fail, mem_bus.write_read, mem_bus.address, mem_bus.wdata, fail_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fault_free;
    logic wr; logic [3:0] a; logic [7:0] d; logic [2:0] e;
    fault_mode = 0;
    do_run(1'b0);
    for (int k = 0; k < NOPS; k++) begin
      op_of(k, wr, a, d, e);
      n_checks++;
      if (lg_wdata[k+1] !== (wr ? d : 8'h00)) begin
        n_fail++;
        $display("FAIL ff_wdata op %0d: got %h expected %h", k, lg_wdata[k+1], wr ? d : 8'h00);
      end
      n_checks++;
      if ({lg_wr[k+2], lg_addr[k+2]} !== {wr, a}) begin
        n_fail++;
        $display("FAIL ff_cmd op %0d: got wr=%b addr=%0d expected wr=%b addr=%0d",
                 k, lg_wr[k+2], lg_addr[k+2], wr, a);
      end
    end
    // Element 3 read addresses descend 15..0 (its reads are ops 80,82,..).
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (lg_addr[80 + 2*i + 2] !== 4'(15 - i) || lg_wr[80 + 2*i + 2] !== 1'b0) begin
        n_fail++;
        $display("FAIL ff_elem3_addr %0d: got addr=%0d wr=%b expected addr=%0d read",
                 i, lg_addr[80 + 2*i + 2], lg_wr[80 + 2*i + 2], 15 - i);
      end
    end
    n_checks++;
    if ({lg_wr[1], lg_addr[1], lg_wr[162], lg_addr[162], lg_wdata[161]} !== '0) begin
      n_fail++;
      $display("FAIL ff_idle_edges: c1 wr=%b addr=%0d c162 wr=%b addr=%0d c161 wdata=%h, expected zero",
               lg_wr[1], lg_addr[1], lg_wr[162], lg_addr[162], lg_wdata[161]);
    end
    n_checks++;
    if ({lg_busy[0], lg_busy[1], lg_busy[163], lg_busy[164]} !== 4'b0110) begin
      n_fail++;
      $display("FAIL ff_busy: c0/c1/c163/c164 = %b%b%b%b expected 0110",
               lg_busy[0], lg_busy[1], lg_busy[163], lg_busy[164]);
    end
    n_checks++;
    if ({lg_done[1], lg_done[163], lg_done[164]} !== 3'b001) begin
      n_fail++;
      $display("FAIL ff_done: c1/c163/c164 = %b%b%b expected 001", lg_done[1], lg_done[163], lg_done[164]);
    end
    n_checks++;
    if (fail !== 1'b0 || fail_count !== 8'd0) begin
      n_fail++;
      $display("FAIL ff_result: fail=%b count=%0d expected 0/0", fail, fail_count);
    end
  endtask

  task automatic test_stuck_at;
    fault_mode = 1;
    do_run(1'b0);
    n_checks++;
    if ({fail, fail_addr, fail_elem, fail_syn, fail_count} !== {1'b1, 4'd5, 3'd1, 8'h08, 8'd3}) begin
      n_fail++;
      $display("FAIL stuck_diag: fail=%b addr=%0d elem=%0d syn=%h count=%0d expected 1/5/1/08/3",
               fail, fail_addr, fail_elem, fail_syn, fail_count);
    end
    n_checks++;
    if (lg_done[164] !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_done: c164 done=%b expected 1", lg_done[164]);
    end
  endtask

  task automatic test_second_start;
    fault_mode = 0;
    do_run(1'b0);
    n_checks++;
    if ({lg_fail[0], lg_done[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL restart_before: c0 fail=%b done=%b expected 1/1", lg_fail[0], lg_done[0]);
    end
    n_checks++;
    if ({lg_fail[1], lg_cnt[1], lg_done[1], lg_busy[1]} !== {1'b0, 8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_clear: c1 fail=%b cnt=%0d done=%b busy=%b expected 0/0/0/1",
               lg_fail[1], lg_cnt[1], lg_done[1], lg_busy[1]);
    end
    n_checks++;
    if ({lg_done[163], lg_done[164], fail} !== 3'b010) begin
      n_fail++;
      $display("FAIL restart_done: c163 done=%b c164 done=%b fail=%b expected 0/1/0",
               lg_done[163], lg_done[164], fail);
    end
  endtask

  task automatic test_coupling;
    int rc; logic [3:0] ra; logic [2:0] re; logic [7:0] rs;
    fault_mode = 2;
    ref_march(rc, ra, re, rs);
    do_run(1'b0);
    n_checks++;
    if (fail !== 1'b1 || fail_addr !== 4'(CF_ADDR)) begin
      n_fail++;
      $display("FAIL coupling_addr: fail=%b addr=%0d expected 1/%0d", fail, fail_addr, CF_ADDR);
    end
    n_checks++;
    if ({fail_elem, fail_syn, fail_count} !== {re, rs, 8'(rc)} || fail_addr !== ra) begin
      n_fail++;
      $display("FAIL coupling_model: addr=%0d elem=%0d syn=%h count=%0d expected %0d/%0d/%h/%0d",
               fail_addr, fail_elem, fail_syn, fail_count, ra, re, rs, rc);
    end
  endtask

  task automatic test_start_ignored;
    logic wr; logic [3:0] a; logic [7:0] d; logic [2:0] e;
    fault_mode = 0;
    do_run(1'b1);
    for (int k = 0; k < NOPS; k++) begin
      op_of(k, wr, a, d, e);
      n_checks++;
      if ({lg_wdata[k+1], lg_wr[k+2], lg_addr[k+2]} !== {(wr ? d : 8'h00), wr, a}) begin
        n_fail++;
        $display("FAIL ignore_seq op %0d: got wdata=%h wr=%b addr=%0d expected %h/%b/%0d",
                 k, lg_wdata[k+1], lg_wr[k+2], lg_addr[k+2], wr ? d : 8'h00, wr, a);
      end
    end
    n_checks++;
    if ({lg_busy[21], lg_busy[101], lg_busy[163], lg_busy[164], lg_done[163], lg_done[164]} !== 6'b111001) begin
      n_fail++;
      $display("FAIL ignore_timing: busy c21/c101/c163/c164=%b%b%b%b done c163/c164=%b%b expected 1110/01",
               lg_busy[21], lg_busy[101], lg_busy[163], lg_busy[164], lg_done[163], lg_done[164]);
    end
  endtask

  task automatic test_reset_mid_run;
    logic wr; logic [3:0] a; logic [7:0] d; logic [2:0] e;
    fault_mode = 0;
    for (int r = 0; r < 50; r++) begin
      @(negedge clk);
      start = (r == 0);
    end
    @(negedge clk);  // cycle 50
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_busy: busy=%b expected 1 before reset", busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_bus.write_read, mem_bus.address, mem_bus.wdata, busy, done, fail,
         fail_addr, fail_elem, fail_syn, fail_count} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: busy=%b done=%b wr=%b addr=%0d wdata=%h expected all zero",
               busy, done, mem_bus.write_read, mem_bus.address, mem_bus.wdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_bus.write_read, mem_bus.address, mem_bus.wdata, busy, done} !== '0) begin
        n_fail++;
        $display("FAIL post_reset_idle %0d: wr=%b addr=%0d wdata=%h busy=%b done=%b expected zero",
                 i, mem_bus.write_read, mem_bus.address, mem_bus.wdata, busy, done);
      end
    end
    do_run(1'b0);
    for (int k = 0; k < NOPS; k++) begin
      op_of(k, wr, a, d, e);
      n_checks++;
      if ({lg_wdata[k+1], lg_wr[k+2], lg_addr[k+2]} !== {(wr ? d : 8'h00), wr, a}) begin
        n_fail++;
        $display("FAIL rerun_seq op %0d: got wdata=%h wr=%b addr=%0d expected %h/%b/%0d",
                 k, lg_wdata[k+1], lg_wr[k+2], lg_addr[k+2], wr ? d : 8'h00, wr, a);
      end
    end
    n_checks++;
    if ({lg_done[163], lg_done[164], fail} !== 3'b010) begin
      n_fail++;
      $display("FAIL rerun_done: c163 done=%b c164 done=%b fail=%b expected 0/1/0",
               lg_done[163], lg_done[164], fail);
    end
  endtask

  initial begin
    fault_mode = 0;
    test_reset();
    test_fault_free();
    test_stuck_at();
    test_second_start();
    test_coupling();
    test_start_ignored();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
